// File: rtl/quad_encoder_array.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_array
//  Description : Multi-channel quadrature decoder with synchronizers, per-bit
//                glitch filters, x1/x2/x4 decode and signed position counters.
//  Revision    : 1.0 - initial release
// ============================================================================

module quad_encoder_array #(
    parameter int CHANNELS      = 2,
    parameter int COUNT_WIDTH   = 16,
    parameter int FILTER_CYCLES = 4,
    parameter int SATURATE      = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS-1:0]             enc_A,
    input  logic [CHANNELS-1:0]             enc_B,
    input  logic [2*CHANNELS-1:0]           mode,
    input  logic [CHANNELS-1:0]             clear,
    output logic [CHANNELS-1:0]             rotary_event,
    output logic [CHANNELS-1:0]             rotary_left,
    output logic [COUNT_WIDTH*CHANNELS-1:0] position,
    output logic [CHANNELS-1:0]             error
);

    localparam int c_CNT_W  = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_CYCLES - 1);

    // Sync (2) + filter (FILTER_CYCLES) + decode (1): the first filtered change
    // after reset is the settling of the held input and must not be counted.
    localparam int c_SETTLE = FILTER_CYCLES + 3;
    localparam int c_BOOT_W = $clog2(c_SETTLE + 1);

    localparam logic [COUNT_WIDTH-1:0] c_POS_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
    localparam logic [COUNT_WIDTH-1:0] c_POS_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
    localparam bit c_SAT = (SATURATE != 0);

    logic [c_BOOT_W-1:0] r_boot;
    logic                w_settled;

    assign w_settled = (r_boot == c_BOOT_W'(c_SETTLE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_boot <= '0;
        end else if (!w_settled) begin
            r_boot <= r_boot + c_BOOT_W'(1);
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [1:0]             w_raw;
        logic [1:0]             w_filt;
        logic [1:0]             w_mode;
        logic [1:0]             r_prev;
        logic                   w_a_ch;
        logic                   w_b_ch;
        logic                   w_illegal;
        logic                   w_right;
        logic                   w_count;
        logic [COUNT_WIDTH-1:0] w_pos_step;
        logic [COUNT_WIDTH-1:0] r_pos;
        logic                   r_err;
        logic                   r_evt;
        logic                   r_left;

        // Bit 1 carries phase A, bit 0 carries phase B.
        assign w_raw  = {enc_A[ch], enc_B[ch]};
        assign w_mode = mode[2*ch +: 2];

        for (genvar b = 0; b < 2; b++) begin : g_bit
            logic               r_sync1;
            logic               r_sync2;
            logic               r_filt;
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_filt  <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[b];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_filt <= r_sync2;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            end

            assign w_filt[b] = r_filt;
        end

        // Right sequence 00->10->11->01->00: an A edge is rightward when the new
        // A differs from B, a B edge when the new A equals B.
        always_comb begin
            w_a_ch    = w_filt[1] ^ r_prev[1];
            w_b_ch    = w_filt[0] ^ r_prev[0];
            w_illegal = w_a_ch & w_b_ch;
            w_right   = w_a_ch ? (w_filt[1] ^ w_filt[0]) : ~(w_filt[1] ^ w_filt[0]);
            w_count   = 1'b0;
            if (w_a_ch ^ w_b_ch) begin
                case (w_mode)
                    2'b00:   w_count = w_a_ch & ~w_filt[0];
                    2'b01:   w_count = w_a_ch;
                    default: w_count = 1'b1;
                endcase
            end
        end

        always_comb begin
            w_pos_step = w_right ? (r_pos + COUNT_WIDTH'(1)) : (r_pos - COUNT_WIDTH'(1));
            if (c_SAT) begin
                if ((w_right && (r_pos == c_POS_MAX)) || (!w_right && (r_pos == c_POS_MIN))) begin
                    w_pos_step = r_pos;
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_prev <= 2'b00;
                r_pos  <= '0;
                r_err  <= 1'b0;
                r_evt  <= 1'b0;
                r_left <= 1'b0;
            end else begin
                r_prev <= w_filt;
                r_evt  <= 1'b0;
                r_left <= 1'b0;
                if (clear[ch]) begin
                    r_pos <= '0;
                    r_err <= 1'b0;
                end else if (w_settled) begin
                    if (w_illegal) begin
                        r_err <= 1'b1;
                    end else if (w_count) begin
                        r_pos  <= w_pos_step;
                        r_evt  <= 1'b1;
                        r_left <= ~w_right;
                    end
                end
            end
        end

        assign position[COUNT_WIDTH*ch +: COUNT_WIDTH] = r_pos;
        assign error[ch]        = r_err;
        assign rotary_event[ch] = r_evt;
        assign rotary_left[ch]  = r_left;
    end

endmodule

`default_nettype wire

// File: tb/tb_quad_encoder_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quad_encoder_array
//  Description : Directed self-checking bench for quad_encoder_array.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_quad_encoder_array;

    logic        clk;
    logic        rst;
    logic [1:0]  enc_A;
    logic [1:0]  enc_B;
    logic [3:0]  mode;
    logic [1:0]  clear;
    logic [1:0]  rotary_event;
    logic [1:0]  rotary_left;
    logic [31:0] position;
    logic [1:0]  error;

    logic        enc_A4;
    logic        enc_B4;
    logic        evt_w, left_w, err_w;
    logic        evt_s, left_s, err_s;
    logic [3:0]  pos_w;
    logic [3:0]  pos_s;

    int checks   = 0;
    int failures = 0;
    int ev0 = 0, lf0 = 0, ev1 = 0, evs = 0, lfs = 0, left_bad = 0;
    int b_ev0, b_lf0, b_ev1, b_evs, b_lfs;

    quad_encoder_array #(
        .CHANNELS(2), .COUNT_WIDTH(16), .FILTER_CYCLES(4), .SATURATE(0)
    ) dut (
        .clk(clk), .rst(rst), .enc_A(enc_A), .enc_B(enc_B), .mode(mode),
        .clear(clear), .rotary_event(rotary_event), .rotary_left(rotary_left),
        .position(position), .error(error)
    );

    quad_encoder_array #(
        .CHANNELS(1), .COUNT_WIDTH(4), .FILTER_CYCLES(4), .SATURATE(0)
    ) dut_w (
        .clk(clk), .rst(rst), .enc_A(enc_A4), .enc_B(enc_B4), .mode(2'b10),
        .clear(1'b0), .rotary_event(evt_w), .rotary_left(left_w),
        .position(pos_w), .error(err_w)
    );

    quad_encoder_array #(
        .CHANNELS(1), .COUNT_WIDTH(4), .FILTER_CYCLES(4), .SATURATE(1)
    ) dut_s (
        .clk(clk), .rst(rst), .enc_A(enc_A4), .enc_B(enc_B4), .mode(2'b10),
        .clear(1'b0), .rotary_event(evt_s), .rotary_left(left_s),
        .position(pos_s), .error(err_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        ev0 += int'(rotary_event[0]);
        lf0 += int'(rotary_left[0]);
        ev1 += int'(rotary_event[1]);
        evs += int'(evt_s);
        lfs += int'(left_s);
        if ((rotary_left & ~rotary_event) != 2'b00) left_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] ab);
        enc_A[ch] = ab[1];
        enc_B[ch] = ab[0];
    endtask

    task automatic walk(input int ch, input logic [7:0] seq, input int n, input int hold);
        for (int i = 0; i < n; i++) begin
            set_ch(ch, seq[7-2*i -: 2]);
            cyc(hold);
        end
    endtask

    task automatic set4(input logic [1:0] ab);
        enc_A4 = ab[1];
        enc_B4 = ab[0];
    endtask

    task automatic pulse_clear(input int ch);
        clear[ch] = 1'b1;
        cyc(1);
        clear[ch] = 1'b0;
        cyc(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rseq [4];
        rseq = '{2'b10, 2'b11, 2'b01, 2'b00};

        rst    = 1'b1;
        enc_A  = 2'b10;     // ch1 held at 11 through reset
        enc_B  = 2'b10;
        enc_A4 = 1'b0;
        enc_B4 = 1'b0;
        mode   = 4'b1010;
        clear  = 2'b00;
        #2 rst = 1'b0;
        #1;
        check("rst_pos",   position, 32'h0);
        check("rst_evt",   {30'h0, rotary_event}, 32'h0);
        check("rst_err",   {30'h0, error}, 32'h0);
        cyc(3);
        rst = 1'b1;
        cyc(20);
        check("settle_pos",  position, 32'h0);
        check("settle_err",  {30'h0, error}, 32'h0);
        check("settle_ev1",  ev1, 0);

        // x4 full right cycle with latency check
        b_ev0 = ev0; b_lf0 = lf0;
        set_ch(0, 2'b10);
        cyc(6);
        check("lat_early", {31'h0, rotary_event[0]}, 32'h0);
        cyc(1);
        check("lat_evt",   {31'h0, rotary_event[0]}, 32'h1);
        check("lat_left",  {31'h0, rotary_left[0]}, 32'h0);
        check("lat_pos",   {16'h0, position[15:0]}, 32'h1);
        cyc(13);
        walk(0, 8'b11_01_00_00, 3, 20);
        check("x4_events", ev0 - b_ev0, 4);
        check("x4_lefts",  lf0 - b_lf0, 0);
        check("x4_pos",    {16'h0, position[15:0]}, 32'h4);

        pulse_clear(0);
        check("clr_pos",   {16'h0, position[15:0]}, 32'h0);

        // reverse in x2 then x1
        mode[1:0] = 2'b01;
        b_ev0 = ev0; b_lf0 = lf0;
        walk(0, 8'b01_11_10_00, 4, 20);
        check("x2_pos",    {16'h0, position[15:0]}, 32'hFFFE);
        check("x2_events", ev0 - b_ev0, 2);
        check("x2_lefts",  lf0 - b_lf0, 2);
        mode[1:0] = 2'b00;
        b_ev0 = ev0; b_lf0 = lf0;
        walk(0, 8'b01_11_10_00, 4, 20);
        check("x1_pos",    {16'h0, position[15:0]}, 32'hFFFD);
        check("x1_events", ev0 - b_ev0, 1);
        check("x1_lefts",  lf0 - b_lf0, 1);

        // 2-cycle glitch on A
        mode[1:0] = 2'b10;
        b_ev0 = ev0;
        enc_A[0] = 1'b1;
        cyc(2);
        enc_A[0] = 1'b0;
        cyc(20);
        check("glitch_ev",  ev0 - b_ev0, 0);
        check("glitch_pos", {16'h0, position[15:0]}, 32'hFFFD);

        // simultaneous A/B change
        b_ev0 = ev0;
        set_ch(0, 2'b11);
        cyc(20);
        check("ill_err",  {31'h0, error[0]}, 32'h1);
        check("ill_ev",   ev0 - b_ev0, 0);
        check("ill_pos",  {16'h0, position[15:0]}, 32'hFFFD);
        check("ill_err1", {31'h0, error[1]}, 32'h0);
        pulse_clear(0);
        check("ill_clr_err", {31'h0, error[0]}, 32'h0);
        check("ill_clr_pos", {16'h0, position[15:0]}, 32'h0);

        // 4-bit wrap vs saturate
        for (int i = 0; i < 7; i++) begin
            set4(rseq[i % 4]);
            cyc(12);
        end
        check("w_pos7", {28'h0, pos_w}, 32'h7);
        check("s_pos7", {28'h0, pos_s}, 32'h7);
        b_evs = evs; b_lfs = lfs;
        set4(2'b00);
        cyc(12);
        check("w_wrap",  {28'h0, pos_w}, 32'h8);
        check("s_hold",  {28'h0, pos_s}, 32'h7);
        check("s_event", evs - b_evs, 1);
        check("s_left",  lfs - b_lfs, 0);
        set4(2'b01);
        cyc(12);
        check("w_unwrap", {28'h0, pos_w}, 32'h7);
        check("s_dec",    {28'h0, pos_s}, 32'h6);

        // async reset mid-rotation, both channels stepping together
        set_ch(0, 2'b01);
        set_ch(1, 2'b10);
        cyc(7);
        check("dual_evt",  {30'h0, rotary_event}, 32'h3);
        check("dual_left", {30'h0, rotary_left}, 32'h2);
        check("dual_pos",  position, 32'hFFFF_0001);
        #2 rst = 1'b0;
        #1;
        check("async_evt",  {30'h0, rotary_event}, 32'h0);
        check("async_left", {30'h0, rotary_left}, 32'h0);
        check("async_pos",  position, 32'h0);
        check("async_err",  {30'h0, error}, 32'h0);
        cyc(2);
        rst = 1'b1;
        b_ev0 = ev0; b_ev1 = ev1;
        cyc(20);
        check("resettle_ev",  (ev0 - b_ev0) + (ev1 - b_ev1), 0);
        check("resettle_pos", position, 32'h0);

        // clear coincident with a step on ch1
        set_ch(1, 2'b11);
        cyc(20);
        check("ch1_pos1", {16'h0, position[31:16]}, 32'h1);
        b_ev1 = ev1;
        set_ch(1, 2'b01);
        cyc(6);
        clear[1] = 1'b1;
        cyc(1);
        clear[1] = 1'b0;
        check("clrstep_evt", {31'h0, rotary_event[1]}, 32'h0);
        check("clrstep_pos", {16'h0, position[31:16]}, 32'h0);
        cyc(20);
        check("clrstep_ev",   ev1 - b_ev1, 0);
        check("clrstep_pos2", {16'h0, position[31:16]}, 32'h0);
        check("left_only_with_event", left_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
